maf_issue: RTL and testbench
============================

# maf_issue

Issue and result-collection front end for the `maf` multiply-add unit (a×b+c, IEEE-754 single precision). It accepts operand triplets over a valid/ready handshake and drives `maf`'s `op_vld`/`nj_mode`/`a`/`b`/`c` inputs. It captures each `res` on `res_rdy` into an in-order result FIFO with a valid/ready output. Because `maf` cannot be stalled, issue is credit-gated: an operation is accepted only when a FIFO slot is guaranteed for its result.

## Interface
- `DEPTH`, 8: result FIFO entries; also the maximum number of reserved (in-flight plus stored) results. Power of two, 2..32.
- `CNT_W`, 4: counter width; must hold the value `DEPTH` (≥ log2(DEPTH)+1).

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_vld` input 1: operand triplet valid.
- `in_rdy` output 1: triplet accepted when `in_vld && in_rdy`.
- `in_nj_mode` input 1: 1 = non-java mode, 0 = java mode.
- `in_a`, `in_b`, `in_c` input 32 each: operands.
- `op_vld` output 1: to `maf`.
- `nj_mode` output 1: to `maf`.
- `a`, `b`, `c` output 32 each: to `maf`.
- `res` input 32: from `maf`.
- `res_rdy` input 1: from `maf`; `res` is valid this cycle.
- `out_vld` output 1: result available.
- `out_rdy` input 1: result popped when `out_vld && out_rdy`.
- `out_res` output 32: FIFO head.
- `busy` output 1: `inflight != 0` or FIFO not empty.
- `err_spur` output 1: sticky flag; a `res_rdy` arrived with `inflight == 0`.

## Operation
- **Counters.**
  - `inflight` (CNT_W): accepted operations whose result has not yet returned.
  - `count` (CNT_W): FIFO occupancy.
- **Acceptance.**
  - `in_rdy = rst_n && (inflight + count < DEPTH)`, computed from registered values only.
  - A pop in the same cycle does not raise `in_rdy` until the next cycle.
- **Accept.** Register the triplet to `a`/`b`/`c`/`nj_mode` with `op_vld = 1` for exactly one cycle.
- **Idle cycles.** With no accept, the next cycle has `op_vld = 0` and `a`, `b`, `c`, `nj_mode` driven to 0.
- **inflight update:** +1 on accept; −1 on a non-spurious `res_rdy`. Both in the same cycle leave it unchanged.
- **Capture.** When `res_rdy` and `inflight != 0`: write `res` to `mem[wr_ptr]`, advance `wr_ptr`, and increment `count`.
- **Pop.** On a pop, advance `rd_ptr` and decrement `count`. A simultaneous push and pop leaves `count` unchanged.
- **Overflow.** The credit rule guarantees no push when full. An assertion checks `count == DEPTH` never coincides with a push.
- **Spurious result.** `res_rdy` with `inflight == 0`: discard `res`, set `err_spur`. `count` and `inflight` are unchanged.
- **Pointers.** `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH.
- **Head output.** `out_vld = (count != 0)`; `out_res = mem[rd_ptr]`.
- **Ordering.** `maf` is in-order, so results leave in acceptance order.
- **Reset** (`rst_n` low at a clock edge):
  - `op_vld`, `nj_mode`, `a`, `b`, `c` = 0.
  - `inflight`, `count`, `wr_ptr`, `rd_ptr`, `err_spur` = 0.
  - Hence `out_vld = 0`, `busy = 0`, `in_rdy = 0` while reset is held.
  - FIFO contents are not reset, and `out_res` is don't-care when `out_vld = 0`.
- **Reset mid-operation.** Results still in the `maf` pipeline return with `inflight == 0`. They are discarded and set `err_spur`.

## Timing
- Accept at cycle T → `op_vld` high at T+1.
- `maf` asserts `res_rdy` at T+1+L (L = `maf` latency).
- The result is pushed at that edge, so `out_vld`/`out_res` are valid at T+2+L.
- Minimum input-to-output latency is L+2 cycles.
- Throughput is 1 op/cycle with `out_rdy` held high, provided `DEPTH ≥ L+2`. Otherwise credits limit the rate to DEPTH per L+2 cycles.
- `in_rdy` and `out_vld` are combinational from registers only, with no path from `in_vld`/`out_rdy`.
- `err_spur` is registered and rises one cycle after the offending `res_rdy`.

## Test plan
Bench uses a behavioural `maf` model with L = 3, DEPTH = 8.
1. **Reset.** Hold `rst_n` = 0 for 2 cycles with `in_vld` = 1. Expect `in_rdy` = 0, `op_vld` = 0, `out_vld` = 0, `busy` = 0, `err_spur` = 0. After release, `in_rdy` = 1.
2. **Single op.** Accept at T: `a` = 0x3F800000, `b` = 0x40000000, `c` = 0x40400000, `nj_mode` = 1. Expect `op_vld` = 1 only at T+1 with those values. Expect `out_vld` = 1 at T+5 with `out_res` = 0x40A00000; pop drops `out_vld` and `busy`.
3. **Backpressure.** `out_rdy` = 0, `in_vld` held high. Expect exactly 8 accepts, then `in_rdy` = 0 with no FIFO overflow. Setting `out_rdy` = 1 then drains 8 results in issue order, and `in_rdy` reasserts the cycle after the first pop.
4. **Streaming.** `out_rdy` = 1, 20 back-to-back ops (`a` = i, `b` = 1.0, `c` = 0). Expect `in_rdy` never deasserts, `op_vld` high for 20 consecutive cycles, and 20 results in order with no gaps.
5. **Full push/pop.** FIFO at 7 with 1 in flight; `res_rdy` and a pop occur in the same cycle. Expect `count` to stay 7, `inflight` to go to 0, and data order preserved.
6. **Spurious/reset mid-op.** Apply reset with 3 ops in flight. Expect the 3 late `res_rdy` to be discarded, `err_spur` = 1 one cycle after the first of them, and `out_vld` to stay 0.

Source files
------------

// File: rtl/maf_issue.sv
// Issue / result-collection front end for the maf multiply-add unit.
// Credit-gated issue guarantees every result in flight has a FIFO slot waiting.
module maf_issue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic        in_nj_mode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  output logic        op_vld,
  output logic        nj_mode,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] c,
  input  logic [31:0] res,
  input  logic        res_rdy,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_res,
  output logic        busy,
  output logic        err_spur
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      mem [DEPTH];
  logic [CNT_W:0]   reserved;
  logic             accept;
  logic             push;
  logic             pop;
  logic             spur;

  // Credits: every accepted op owns a slot until its result is popped.
  assign reserved = {1'b0, inflight} + {1'b0, count};
  assign in_rdy   = rst_n && (reserved < (CNT_W+1)'(DEPTH));
  assign accept   = in_vld && in_rdy;
  assign push     = res_rdy && (inflight != '0);
  assign spur     = res_rdy && (inflight == '0);
  assign out_vld  = (count != '0);
  assign pop      = out_vld && out_rdy;
  assign out_res  = mem[rd_ptr];
  assign busy     = (inflight != '0) || (count != '0);

  // Issue stage: operands go to maf one cycle after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_vld   <= 1'b0;
      nj_mode  <= 1'b0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err_spur <= 1'b0;
    end else begin
      op_vld  <= accept;
      nj_mode <= accept & in_nj_mode;
      a       <= accept ? in_a : '0;
      b       <= accept ? in_b : '0;
      c       <= accept ? in_c : '0;

      case ({accept, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // Results returning after a mid-operation reset land here.
      if (spur) err_spur <= 1'b1;
    end
  end

  // Result capture stage: storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && count == CNT_W'(DEPTH)))
      else $error("maf_issue result FIFO overflow");
  end

endmodule

// File: tb/tb_maf_issue.sv
// Directed bench for maf_issue with a behavioural 3-cycle maf model and
// an in-order result scoreboard.
module tb_maf_issue;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic        in_nj_mode;
  logic [31:0] in_a, in_b, in_c;
  logic        op_vld;
  logic        nj_mode;
  logic [31:0] a, b, c;
  logic [31:0] res;
  logic        res_rdy;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_res;
  logic        busy;
  logic        err_spur;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int op_run = 0, max_op_run = 0;
  int out_run = 0, max_out_run = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  maf_issue #(.DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_nj_mode(in_nj_mode), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .op_vld(op_vld), .nj_mode(nj_mode), .a(a), .b(b), .c(c),
    .res(res), .res_rdy(res_rdy), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_res(out_res), .busy(busy), .err_spur(err_spur)
  );

  // Single-precision <-> real for zero and normal numbers only.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] maf_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
    return r2sp(sp2r(x) * sp2r(y) + sp2r(z));
  endfunction

  // Behavioural maf: not reset, so results keep returning across a DUT reset.
  logic [L-1:0] pv = '0;
  logic [31:0]  pr [L];
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], (op_vld === 1'b1)};
    pr[0] <= maf_fn(a, b, c);
    for (int k = 1; k < L; k++) pr[k] <= pr[k-1];
  end
  assign res_rdy = pv[L-1];
  assign res     = pr[L-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard and run-length monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (in_vld === 1'b1 && in_rdy === 1'b1) begin
      exp_q.push_back(maf_fn(in_a, in_b, in_c));
      n_acc++;
    end
    if (out_vld === 1'b1 && out_rdy === 1'b1) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL pop_empty observed=%h expected=no_result", out_res);
      end
      if (exp_q.size() != 0) chk("order", out_res, exp_q.pop_front());
    end
    op_run  = (op_vld === 1'b1) ? op_run + 1 : 0;
    out_run = (out_vld === 1'b1) ? out_run + 1 : 0;
    if (op_run > max_op_run) max_op_run = op_run;
    if (out_run > max_out_run) max_out_run = out_run;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && (exp_q.size() != 0 || out_vld === 1'b1); k++) step();
    chk(tag, exp_q.size(), 0);
    chk({tag, "_out_vld"}, out_vld, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int found;
    rst_n = 1'b0; in_vld = 1'b1; in_nj_mode = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; out_rdy = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_op_vld", op_vld, 1'b0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_spur", err_spur, 1'b0);
    in_vld = 1'b0;
    rst_n  = 1'b1;
    #1;
    chk("post_rst_in_rdy", in_rdy, 1'b1);

    // 2. single op (cycle T)
    step();
    in_vld = 1'b1; in_nj_mode = 1'b1;
    in_a = 32'h3F800000; in_b = 32'h40000000; in_c = 32'h40400000;
    step();                                     // T+1
    in_vld = 1'b0; in_nj_mode = 1'b0;
    chk("t2_op_vld", op_vld, 1'b1);
    chk("t2_a", a, 32'h3F800000);
    chk("t2_b", b, 32'h40000000);
    chk("t2_c", c, 32'h40400000);
    chk("t2_nj", nj_mode, 1'b1);
    step();                                     // T+2
    chk("t2_op_vld_low", op_vld, 1'b0);
    chk("t2_a_idle", a, 32'd0);
    chk("t2_nj_idle", nj_mode, 1'b0);
    step(); step();                             // T+4
    chk("t2_out_vld_early", out_vld, 1'b0);
    step();                                     // T+5
    chk("t2_out_vld", out_vld, 1'b1);
    chk("t2_out_res", out_res, 32'h40A00000);
    chk("t2_busy", busy, 1'b1);
    out_rdy = 1'b1;
    step();
    chk("t2_out_vld_popped", out_vld, 1'b0);
    chk("t2_busy_idle", busy, 1'b0);
    out_rdy = 1'b0;

    // 3. backpressure
    base = n_acc;
    in_vld = 1'b1; in_b = r2sp(1.0); in_c = 32'd0;
    for (int i = 0; i < 16; i++) begin
      in_a = r2sp($itor(i + 1));
      step();
    end
    in_vld = 1'b0;
    chk("t3_accepts", n_acc - base, 8);
    chk("t3_in_rdy", in_rdy, 1'b0);
    chk("t3_count", 32'(dut.count), 8);
    chk("t3_out_vld", out_vld, 1'b1);
    out_rdy = 1'b1;
    #1;
    chk("t3_in_rdy_same", in_rdy, 1'b0);
    step();
    chk("t3_in_rdy_after", in_rdy, 1'b1);
    drain("t3_drain");

    // 4. streaming
    max_op_run = 0; max_out_run = 0;
    for (int i = 0; i < 20; i++) begin
      chk("t4_in_rdy", in_rdy, 1'b1);
      in_vld = 1'b1; in_a = r2sp($itor(i)); in_b = r2sp(1.0); in_c = 32'd0;
      step();
    end
    in_vld = 1'b0;
    drain("t4_drain");
    chk("t4_op_run", max_op_run, 20);
    chk("t4_out_run", max_out_run, 20);

    // 5. push and pop together with FIFO at 7, one in flight
    out_rdy = 1'b0;
    in_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = r2sp($itor(100 + i));
      step();
    end
    in_vld = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      step();
      if (dut.count == 4'd7) found = 1;
    end
    chk("t5_reached7", found, 1);
    chk("t5_inflight1", 32'(dut.inflight), 1);
    chk("t5_res_rdy", res_rdy, 1'b1);
    out_rdy = 1'b1;
    step();
    chk("t5_count7", 32'(dut.count), 7);
    chk("t5_inflight0", 32'(dut.inflight), 0);
    drain("t5_drain");
    chk("t5_err_spur", err_spur, 1'b0);

    // 6. reset with 3 ops in flight
    in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = r2sp($itor(7 + i));
      step();
    end
    in_vld = 1'b0;
    chk("t6_inflight3", 32'(dut.inflight), 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    chk("t6_res_rdy", res_rdy, 1'b1);
    chk("t6_err_before", err_spur, 1'b0);
    step();
    chk("t6_err_spur", err_spur, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_out_vld", out_vld, 1'b0);
      step();
    end
    chk("t6_inflight0", 32'(dut.inflight), 0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_err_sticky", err_spur, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
